// File: rtl/spike_encoder_pkg.sv
// Time-base defines and spike-time type shared by the encoder and the downstream layer.
`ifndef INTERNAL_DEFINES_SVH
`define INTERNAL_DEFINES_SVH
`define LOG_TIME_PERIOD 3
`define TIME_PERIOD 8
`define NUM_SPIKES 4
`endif

package spike_encoder_pkg;

   localparam int unsigned TIME_W = `LOG_TIME_PERIOD + 1;

   typedef struct packed {
      logic                        no_spike;
      logic [`LOG_TIME_PERIOD-1:0] t;
   } spike_t;

   localparam spike_t NO_SPIKE = '{no_spike: 1'b1, t: '0};

   localparam logic [0:0] FILLING = 1'b0;
   localparam logic [0:0] FULL    = 1'b1;
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] ACTIVE  = 1'b1;

endpackage

// File: rtl/intensity_to_spike.sv
// Maps a pixel intensity to a spike time: brighter pixels fire earlier, dim ones not at all.
module intensity_to_spike
   import spike_encoder_pkg::*;
#(
   parameter int PIX_BITS   = 8,
   parameter int PIX_THRESH = 16
) (
   input  logic [PIX_BITS-1:0] pix,
   output spike_t              spike
);

   localparam int LTP = `LOG_TIME_PERIOD;

   logic [PIX_BITS-1:0] inv;

   always_comb begin
      inv   = ~pix;
      spike = NO_SPIKE;
      if (32'(pix) >= PIX_THRESH) begin
         spike.no_spike = 1'b0;
         spike.t        = LTP'(inv >> (PIX_BITS - LTP));
      end
   end

endmodule

// File: rtl/spike_encoder.sv
// Double-buffered pixel-to-spike-time encoder: one frame fills while the previous one is presented.
//
// FSM       | state   | meaning
// fill      | FILLING | accepting pixels into the fill buffer, pix_ready=1
// fill      | FULL    | fill buffer holds a complete frame, waiting for period end
// present   | IDLE    | spike_times is all no-spike, frame_active=0
// present   | ACTIVE  | spike_times holds a captured frame, frame_active=1
module spike_encoder
   import spike_encoder_pkg::*;
#(
   parameter int PIX_BITS   = 8,
   parameter int PIX_THRESH = 16
) (
   input  logic                             clk,
   input  logic                             rst_l,
   input  logic                             pix_valid,
   output logic                             pix_ready,
   input  logic [PIX_BITS-1:0]              pix_data,
   input  logic                             enable,
   output logic [`LOG_TIME_PERIOD:0]        time_val,
   output spike_t [`NUM_SPIKES-1:0]         spike_times,
   output logic                             frame_active,
   output logic                             period_done
);

   localparam int NS    = `NUM_SPIKES;
   localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NS - 1);
   localparam logic [TIME_W-1:0] LAST_T   = TIME_W'(`TIME_PERIOD - 1);

   logic [0:0]          fill_state;
   logic [0:0]          present_state;
   logic [IDX_W-1:0]    fill_idx;
   spike_t [NS-1:0]     fill_buf;
   spike_t              enc;
   logic                accept;
   logic                handover;

   intensity_to_spike #(
      .PIX_BITS   (PIX_BITS),
      .PIX_THRESH (PIX_THRESH)
   ) u_conv (
      .pix   (pix_data),
      .spike (enc)
   );

   assign pix_ready    = (fill_state == FILLING);
   assign accept       = pix_valid && pix_ready;
   assign period_done  = enable && (time_val == LAST_T);
   assign handover     = period_done && (fill_state == FULL);
   assign frame_active = (present_state == ACTIVE);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         time_val <= '0;
      end else if (enable) begin
         if (time_val == LAST_T) time_val <= '0;
         else                    time_val <= time_val + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         fill_state <= FILLING;
         fill_idx   <= '0;
         for (int i = 0; i < NS; i++) fill_buf[i] <= NO_SPIKE;
      end else if (handover) begin
         fill_state <= FILLING;
         fill_idx   <= '0;
      end else if (accept) begin
         fill_buf[fill_idx] <= enc;
         if (fill_idx == LAST_IDX) begin
            fill_state <= FULL;
            fill_idx   <= '0;
         end else begin
            fill_idx <= fill_idx + 1'b1;
         end
      end
   end

   // The presented frame only ever changes at a period boundary, so it is stable for a whole period.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         present_state <= IDLE;
         for (int i = 0; i < NS; i++) spike_times[i] <= NO_SPIKE;
      end else if (period_done) begin
         if (fill_state == FULL) begin
            present_state <= ACTIVE;
            spike_times   <= fill_buf;
         end else begin
            present_state <= IDLE;
            for (int i = 0; i < NS; i++) spike_times[i] <= NO_SPIKE;
         end
      end
   end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter PIX_BITS, default 8: pixel intensity width; PIX_BITS >= `log_time_period.
REQ-002 SHALL have parameter PIX_THRESH, default 16: intensity below this value produces no spike.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_l, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pix_valid, input, 1: pix_data valid this cycle.
REQ-006 SHALL have port pix_ready, output, 1: encoder accepts a pixel this cycle.
REQ-007 SHALL have port pix_data, input, PIX_BITS: pixel intensity, unsigned.
REQ-008 SHALL have port enable, input, 1: advance the time base.
REQ-009 SHALL have port time_val, output, `log_time_period+1: current time step within the period.
REQ-010 SHALL have port spike_times, output, [`num_spikes][`log_time_period+1]: per input, MSB=1 means no spike, low bits give the spike time.
REQ-011 SHALL have port frame_active, output, 1: spike_times carries a real frame this period.
REQ-012 SHALL have port period_done, output, 1: high when enable=1 and time_val==`time_period-1.

Function
REQ-013 Fill buffer SHALL accept pixels in index order 0..`num_spikes-1; a transfer occurs when pix_valid && pix_ready.
REQ-014 Each accepted pixel SHALL be encoded at capture and stored encoded.
- pix < PIX_THRESH: stored value = MSB 1, low bits 0 (no spike).
- otherwise: stored value = MSB 0, time = ((2^PIX_BITS-1) - pix) >> (PIX_BITS - `log_time_period).
REQ-015 Fill FSM SHALL have two states, FILLING and FULL.
- FILLING -> FULL on acceptance of index `num_spikes-1.
- FULL -> FILLING on the cycle the buffer is handed over (REQ-018).
REQ-016 pix_ready SHALL be 1 in FILLING and 0 in FULL; it is driven from registered state, with no combinational path from pix_valid.
REQ-017 time_val SHALL increment by 1 each cycle enable=1, wrap from `time_period-1 to 0, and hold while enable=0.
REQ-018 Handover SHALL occur only on a cycle where period_done=1.
- Fill FSM in FULL: the fill buffer copies to spike_times and frame_active=1 from the next cycle (time_val=0).
- Otherwise: spike_times becomes all no-spike and frame_active=0.
REQ-019 spike_times and frame_active SHALL remain constant for the whole period (time_val 0..`time_period-1), including any enable=0 stall.
REQ-020 After a handover, pix_ready SHALL be 1 on the next cycle; a full second frame SHALL be loadable while the current frame is presented (double buffering).
REQ-021 Pixels presented while pix_ready=0 SHALL be neither consumed nor lost; the source holds them under valid/ready.
REQ-022 Present FSM SHALL have two states, IDLE (frame_active=0) and ACTIVE (frame_active=1), and change state only at handover.

Reset
REQ-023 While rst_l=0, all outputs SHALL take their reset values immediately:
- time_val=0
- spike_times all MSB=1, low bits 0
- frame_active=0
- period_done=0
- pix_ready=1
REQ-024 While rst_l=0, the fill index SHALL be 0 and both FSMs SHALL be in FILLING / IDLE.
REQ-025 Reset mid-frame SHALL discard any partially filled or fully filled buffer.

Structure
REQ-026 `num_spikes, `time_period and `log_time_period SHALL come from the shared internal_defines header; no local redefinition.
REQ-027 A spike-time typedef ({no_spike, time}, `log_time_period+1 bits) SHALL be shared with the layer.
REQ-028 Pixel-to-spike-time conversion SHALL be one combinational sub-module, intensity_to_spike.

Verification (bench: `log_time_period=3, `time_period=8, `num_spikes=4, PIX_BITS=8, PIX_THRESH=16)
REQ-029 Reset, no stimulus -> time_val=0, spike_times={1000,1000,1000,1000}, frame_active=0, pix_ready=1.
REQ-030 Pixels {255,128,16,15} with enable=1 -> at the next time_val=0, spike_times={0000,0011,0111,1000} and frame_active=1 for 8 cycles.
REQ-031 Second frame loaded during the REQ-030 period -> pix_ready=0 until period_done, then 1 one cycle later; the second frame appears at the next time_val=0.
REQ-032 No frame loaded before period_done -> next period frame_active=0 and spike_times all 1000.
REQ-033 enable=0 at time_val=5 for 3 cycles -> time_val holds 5 and spike_times is unchanged; counting resumes to 6 and handover still occurs at 7.
REQ-034 rst_l pulsed after 2 of 4 pixels -> those 2 are discarded; the next 4 pixels {200,0,255,40} present as {0001,1000,0000,0110}.
